alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one `tinyalu` instance among `N_REQ` requesters. It accepts one operation at a time via a req/grant handshake and drives the ALU's `start`/`opcode`/`A`/`B` until `done`. It returns the captured result to the winning requester, with a watchdog timeout for a hung ALU. It sits between the requester agents and the ALU's `alu_interface` signals.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 16: maximum BUSY cycles waiting for `alu_done`, minimum 4.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset_n`  in  1  — reset, asynchronous, active-low.
- `req`  in  N_REQ  — per-requester request; held with operands until granted.
- `req_op`  in  N_REQ×3  — per-requester opcode (`operation_t`).
- `req_a`, `req_b`  in  N_REQ×8  — per-requester operands.
- `grant`  out  N_REQ  — one-hot, registered, one-cycle pulse: the operation has been accepted.
- `rsp_valid`  out  N_REQ  — one-hot, one-cycle pulse to the originating requester.
- `rsp_result`  out  16  — result; valid only while any `rsp_valid` bit is high.
- `rsp_err`  out  1  — timeout flag, qualified by `rsp_valid`.
- `busy`  out  1  — high in BUSY and RESP.
- `alu_start`  out  1, `alu_op`  out  3, `alu_a`  out  8, `alu_b`  out  8 — ALU drive.
- `alu_result`  in  16, `alu_done`  in  1 — ALU return.

## Operation
- FSM states `IDLE`, `BUSY`, `RESP` (`arb_state_t`).
- **IDLE:** if any `req` bit is high at the clock edge:
  - Pick the winner by round-robin, searching upward from `ptr+1` mod `N_REQ`.
  - Latch the winner's index, `req_op`, `req_a` and `req_b` into the ALU drive registers.
  - Pulse `grant[winner]`, set `alu_start=1`, clear the timeout counter, and go to BUSY.
  - If no `req` bit is high, remain in IDLE.
- **BUSY:**
  - Hold `alu_start` and operands constant; increment the counter each cycle.
  - If `alu_done` is sampled high: capture `alu_result`, set `err=0`, drop `alu_start`, go to RESP.
  - If instead `alu_done` is low and the counter equals `TIMEOUT-1`: capture 16'h0000, set `err=1`, drop `alu_start`, go to RESP.
  - If both would apply in the same cycle, `alu_done` wins.
- **RESP:** assert `rsp_valid[winner]` with the captured result and `err`, set `ptr<=winner`, go to IDLE.
- `alu_done` is ignored in IDLE and RESP; a stale `done` is never treated as completion.
- All opcodes are handled identically. For NOP, the arbiter still waits for `done` and returns whatever `alu_result` holds. Opcode values are not range-checked.
- A requester that drops `req` before being granted simply forfeits; no grant is issued.
- `req` from the currently granted requester is not sampled again until the FSM returns to IDLE.

## Timing
- **Reset values:** all outputs 0 (`alu_op`/`alu_a`/`alu_b` = 0), state IDLE, `ptr=N_REQ-1` (requester 0 wins first after reset).
- **Reset mid-operation:** `reset_n` low clears everything immediately and asynchronously. The in-flight operation is dropped and no `rsp_valid` is issued.
- **Single-cycle op example:** `req` sampled at edge 0 → `grant`/`alu_start` high after edge 0 → ALU `done` after edge 1 → sampled at edge 2 → `rsp_valid` high for the cycle after edge 2.
- **Response latency:** always one cycle after `alu_done` is sampled.
- **`alu_start` gap:** `alu_start` is low for at least 2 cycles (RESP plus IDLE) between operations, so the ALU clears `done` before the next start.
- **Issue rate:** back-to-back issue occurs at most every 3 + ALU latency cycles.
- **Timeout:** fires exactly `TIMEOUT` cycles after entering BUSY.
- **Counter width:** `$clog2(TIMEOUT)`; the counter never wraps because it is cleared on BUSY entry.

## Structure
- Add `arb_state_t` and the default `ARB_TIMEOUT` localparam to `alu_pkg`, alongside the existing `operation_t`.
- Sub-module `rr_pick`: combinational round-robin selection, with inputs `req` and `ptr` and outputs one-hot `win` plus `any`. It is reused by other shared-resource arbiters.
- The top level holds the FSM, operand/index registers, the timeout counter and the response registers.

## Test plan
- **Single request:** after reset, `req[2]` with ADD, A=8'h0F, B=8'h01 → `grant[2]` pulse; ALU sees `start` with the same operands; `rsp_valid[2]` with `rsp_result`=16'h0010, `rsp_err`=0.
- **Fairness:** all four requesters hold `req` continuously → grant order 0,1,2,3,0,1, each receiving exactly one `rsp_valid` per grant.
- **Multi-cycle op:** `req[1]` with MUL, A=8'hFF, B=8'hFF → `alu_start` is held until `done` after the ALU's multi-cycle latency → `rsp_result`=16'hFE01.
- **Timeout:** an ALU model never asserts `done`; `TIMEOUT`=16 → `rsp_valid` exactly 16 cycles after `grant`, with `rsp_err`=1 and `rsp_result`=0; the next request is served normally.
- **Reset mid-BUSY:** assert `reset_n` low during a MUL → all outputs 0 immediately, no `rsp_valid`; after release, `req[3]` and `req[0]` together → `grant[0]` first.
- **Withdrawn request:** `req[1]` pulses for half a cycle between edges, or drops while another requester is BUSY → `grant[1]` never asserted, and `alu_start` never seen with requester 1's operands.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU opcode type plus arbiter state encoding and defaults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t BUSY = 2'd1;
  localparam arb_state_t RESP = 2'd2;

  localparam int ARB_TIMEOUT = 16;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin pick, searching upward from ptr+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          any
);

  localparam logic [PW:0] c_N = (PW+1)'(N);

  logic [PW:0]  w_sh;
  logic [N-1:0] w_rot;
  logic [N-1:0] w_low;

  // Rotate so bit 0 is requester ptr+1, take the lowest set bit, rotate back.
  assign w_sh  = {1'b0, ptr} + (PW+1)'(1);
  assign w_rot = N'({req, req} >> w_sh);
  assign w_low = w_rot & (~w_rot + N'(1));
  assign win   = N'({w_low, w_low} >> (c_N - w_sh));
  assign any   = |req;

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sequencer sharing one tinyalu among N_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*3-1:0] req_op,
  input  logic [N_REQ*8-1:0] req_a,
  input  logic [N_REQ*8-1:0] req_b,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [15:0]        rsp_result,
  output logic               rsp_err,
  output logic               busy,
  output logic               alu_start,
  output logic [2:0]         alu_op,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic [15:0]        alu_result,
  input  logic               alu_done
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] c_PTR_RST  = PW'(N_REQ - 1);

  arb_state_t       r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_idx;
  logic [N_REQ-1:0] r_owner;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [15:0]      r_result;
  logic             r_err;
  logic             r_alu_start;
  logic [2:0]       r_alu_op;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [CW-1:0]    r_cnt;

  logic [N_REQ-1:0] w_win;
  logic             w_any;
  logic [PW-1:0]    w_idx;
  logic [2:0]       w_op_arr [N_REQ];
  logic [7:0]       w_a_arr  [N_REQ];
  logic [7:0]       w_b_arr  [N_REQ];

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_op_arr[g] = req_op[g*3 +: 3];
      assign w_a_arr[g]  = req_a[g*8 +: 8];
      assign w_b_arr[g]  = req_b[g*8 +: 8];
    end
  endgenerate

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .win (w_win),
    .any (w_any)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win[i]) w_idx = PW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= c_PTR_RST;
      r_idx       <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_rsp_valid <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_alu_start <= 1'b0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= '0;
          if (w_any) begin
            r_idx       <= w_idx;
            r_owner     <= w_win;
            r_grant     <= w_win;
            r_alu_start <= 1'b1;
            r_alu_op    <= w_op_arr[w_idx];
            r_alu_a     <= w_a_arr[w_idx];
            r_alu_b     <= w_b_arr[w_idx];
            r_cnt       <= '0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          r_grant <= '0;
          // A completion in the last counted cycle still beats the timeout.
          if (alu_done) begin
            r_result    <= alu_result;
            r_err       <= 1'b0;
            r_alu_start <= 1'b0;
            r_rsp_valid <= r_owner;
            r_state     <= RESP;
          end else if (r_cnt == c_CNT_LAST) begin
            r_result    <= 16'h0000;
            r_err       <= 1'b1;
            r_alu_start <= 1'b0;
            r_rsp_valid <= r_owner;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          r_rsp_valid <= '0;
          r_ptr       <= r_idx;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_err    = r_err;
  assign busy       = (r_state != IDLE);
  assign alu_start  = r_alu_start;
  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed scoreboard bench for alu_arbiter with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*3-1:0] req_op;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N-1:0]   grant;
  logic [N-1:0]   rsp_valid;
  logic [15:0]    rsp_result;
  logic           rsp_err;
  logic           busy;
  logic           alu_start;
  logic [2:0]     alu_op;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  logic [15:0]    alu_result;
  logic           alu_done;

  always #5 clk = ~clk;

  alu_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .grant      (grant),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_done   (alu_done)
  );

  typedef struct packed {
    logic [1:0] idx;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } gnt_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] res;
    logic        err;
    logic [7:0]  lat;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  gnt_t mon_g;
  rsp_t mon_r;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   grant_cyc = 0;
  int   acnt;
  logic hang;

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      add_op:  return {8'h00, a} + {8'h00, b};
      and_op:  return {8'h00, a & b};
      xor_op:  return {8'h00, a ^ b};
      mul_op:  return a * b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    return (op == mul_op) ? 3 : 1;
  endfunction

  // Behavioural tinyalu: done pulses after the op latency; hang never finishes.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_done   <= 1'b0;
      alu_result <= 16'h0000;
      acnt       <= 0;
    end else if (!alu_start) begin
      alu_done <= 1'b0;
      acnt     <= 0;
    end else if (alu_done) begin
      alu_done <= 1'b0;
    end else if (hang) begin
      alu_result <= 16'hDEAD;
    end else if (acnt == lat_of(alu_op) - 1) begin
      alu_done   <= 1'b1;
      alu_result <= alu_ref(alu_op, alu_a, alu_b);
    end else begin
      acnt <= acnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (grant != '0) begin
        grant_cyc = cyc;
        if (gnt_q.size() == 0) begin
          check("grant_unexpected", 32'(grant), 32'h0);
        end else begin
          mon_g = gnt_q.pop_front();
          check("grant_onehot", 32'(grant), 32'(1) << mon_g.idx);
          check("grant_alu_start", 32'(alu_start), 32'h1);
          check("grant_alu_op", 32'(alu_op), 32'(mon_g.op));
          check("grant_alu_a", 32'(alu_a), 32'(mon_g.a));
          check("grant_alu_b", 32'(alu_b), 32'(mon_g.b));
        end
      end
      if (rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          mon_r = rsp_q.pop_front();
          check("rsp_onehot", 32'(rsp_valid), 32'(1) << mon_r.idx);
          check("rsp_result", 32'(rsp_result), 32'(mon_r.res));
          check("rsp_err", 32'(rsp_err), 32'(mon_r.err));
          check("rsp_latency", 32'(cyc - grant_cyc), 32'(mon_r.lat));
          check("rsp_busy", 32'(busy), 32'h1);
        end
      end
    end
  end

  task automatic post(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] res, input logic err, input int lat, input bit want_rsp);
    gnt_t g;
    rsp_t r;
    req_op[idx*3 +: 3] = op;
    req_a[idx*8 +: 8]  = a;
    req_b[idx*8 +: 8]  = b;
    g = '{idx: 2'(idx), op: op, a: a, b: b};
    gnt_q.push_back(g);
    if (want_rsp) begin
      r = '{idx: 2'(idx), res: res, err: err, lat: 8'(lat)};
      rsp_q.push_back(r);
    end
  endtask

  task automatic wait_grants(input int n, input bit drop);
    int got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (grant != '0) begin
        got++;
        if (drop) req = req & ~grant;
      end
    end
    check("grant_wait", 32'(got), 32'(n));
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && (rsp_q.size() != 0 || busy); c++) @(negedge clk);
    check("drain_rsp_q", 32'(rsp_q.size()), 32'h0);
    check("drain_idle", 32'(busy), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},  32'(grant), 32'h0);
    check({tag, "_rsp_v"},  32'(rsp_valid), 32'h0);
    check({tag, "_rsp_r"},  32'(rsp_result), 32'h0);
    check({tag, "_rsp_e"},  32'(rsp_err), 32'h0);
    check({tag, "_busy"},   32'(busy), 32'h0);
    check({tag, "_start"},  32'(alu_start), 32'h0);
    check({tag, "_op"},     32'(alu_op), 32'h0);
    check({tag, "_a"},      32'(alu_a), 32'h0);
    check({tag, "_b"},      32'(alu_b), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    req     = '0;
    req_op  = '0;
    req_a   = '0;
    req_b   = '0;
    hang    = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single request from requester 2
    post(2, add_op, 8'h0F, 8'h01, 16'h0010, 1'b0, 2, 1'b1);
    req[2] = 1'b1;
    wait_grants(1, 1'b1);
    drain();

    // Fairness from a fresh pointer: 0,1,2,3,0,1
    do_reset();
    post(0, add_op, 8'h01, 8'h02, 16'h0003, 1'b0, 2, 1'b1);
    post(1, xor_op, 8'hAA, 8'h55, 16'h00FF, 1'b0, 2, 1'b1);
    post(2, and_op, 8'hCC, 8'hAA, 16'h0088, 1'b0, 2, 1'b1);
    post(3, mul_op, 8'h10, 8'h10, 16'h0100, 1'b0, 4, 1'b1);
    post(0, add_op, 8'h01, 8'h02, 16'h0003, 1'b0, 2, 1'b1);
    post(1, xor_op, 8'hAA, 8'h55, 16'h00FF, 1'b0, 2, 1'b1);
    req = 4'hF;
    wait_grants(6, 1'b0);
    req = '0;
    drain();

    // Multi-cycle multiply
    post(1, mul_op, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 4, 1'b1);
    req[1] = 1'b1;
    wait_grants(1, 1'b1);
    drain();

    // Hung ALU times out, then a normal request is served
    hang = 1'b1;
    post(0, xor_op, 8'h12, 8'h34, 16'h0000, 1'b1, TO, 1'b1);
    req[0] = 1'b1;
    wait_grants(1, 1'b1);
    drain();
    hang = 1'b0;
    post(3, and_op, 8'hF0, 8'h3C, 16'h0030, 1'b0, 2, 1'b1);
    req[3] = 1'b1;
    wait_grants(1, 1'b1);
    drain();

    // Request pulse that never spans a rising edge
    req_op[3 +: 3] = add_op;
    req_a[8 +: 8]  = 8'h66;
    req_b[8 +: 8]  = 8'h77;
    req[1] = 1'b1;
    #3 req[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("withdraw_pulse_idle", 32'(busy), 32'h0);

    // Request raised and dropped while another requester is busy
    post(0, mul_op, 8'h03, 8'h05, 16'h000F, 1'b0, 4, 1'b1);
    req[0] = 1'b1;
    wait_grants(1, 1'b1);
    req_op[3 +: 3] = and_op;
    req_a[8 +: 8]  = 8'h99;
    req_b[8 +: 8]  = 8'h88;
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    drain();

    // Reset in the middle of a multiply
    post(1, mul_op, 8'h21, 8'h43, 16'h0000, 1'b0, 0, 1'b0);
    req[1] = 1'b1;
    wait_grants(1, 1'b1);
    @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'h1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    post(0, add_op, 8'h07, 8'h08, 16'h000F, 1'b0, 2, 1'b1);
    post(3, xor_op, 8'hF0, 8'h0F, 16'h00FF, 1'b0, 2, 1'b1);
    req = 4'b1001;
    wait_grants(2, 1'b1);
    drain();

    check("gnt_q_empty", 32'(gnt_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
